// File: rtl/demux_1to2_rr.sv
//------------------------------------------------------------------------------
// demux_1to2_rr
//
// Registered 1:2 demultiplexer. Each word on a single valid/ready input stream
// goes to output lane A or lane B. The lane comes from an explicit select, or
// from a round-robin pointer that alternates between the lanes. Each lane has a
// one-entry output register and a wrapping count of the words it has handed off.
//
// Parameters
//   WIDTH        data width of the input and of both output lanes
//   CNT_W        width of each per-lane handoff counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input word present
//   in_ready     block accepts the input word this cycle (combinational)
//   in_data      input word
//   in_sel       target lane in explicit mode (0 = A, 1 = B)
//   in_mode      0 = explicit select, 1 = round-robin
//   out_a_valid  lane A register holds a word
//   out_a_ready  lane A consumer takes the word
//   out_a_data   lane A word
//   out_b_valid  lane B register holds a word
//   out_b_ready  lane B consumer takes the word
//   out_b_data   lane B word
//   cnt_a        lane A handoff count, wraps modulo 2^CNT_W
//   cnt_b        lane B handoff count, wraps modulo 2^CNT_W
//------------------------------------------------------------------------------
module demux_1to2_rr #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_mode,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_e;

    lane_e rr_ptr;      // lane the next round-robin word goes to
    lane_e target;      // lane the current input word would go to

    logic  tgt_valid;
    logic  tgt_ready;
    logic  accept;
    logic  load_a;
    logic  load_b;
    logic  hand_a;
    logic  hand_b;

    //--------------------------------------------------------------------------
    // Lane selection and input handshake
    //--------------------------------------------------------------------------
    always_comb begin
        target = in_mode ? rr_ptr : lane_e'(in_sel);
    end

    always_comb begin
        tgt_valid = out_a_valid;
        tgt_ready = out_a_ready;
        if (target == LANE_B) begin
            tgt_valid = out_b_valid;
            tgt_ready = out_b_ready;
        end
    end

    // The target register can take a word when it is empty or when its current
    // word leaves on this same edge; the other lane never blocks the input.
    always_comb begin
        in_ready = rst_n & (~tgt_valid | tgt_ready);
    end

    always_comb begin
        accept = in_valid & in_ready;
        load_a = accept & (target == LANE_A);
        load_b = accept & (target == LANE_B);
        hand_a = out_a_valid & out_a_ready;
        hand_b = out_b_valid & out_b_ready;
    end

    //--------------------------------------------------------------------------
    // Round-robin pointer: advances only on round-robin accepts, and holds its
    // value across explicit-mode traffic and mode changes.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= LANE_A;
        end else if (accept && in_mode) begin
            rr_ptr <= (rr_ptr == LANE_A) ? LANE_B : LANE_A;
        end
    end

    //--------------------------------------------------------------------------
    // Lane A output register. A load on the same edge as a handoff wins, so the
    // lane keeps streaming one word per cycle. Data holds after a handoff.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_valid <= 1'b0;
            out_a_data  <= '0;
        end else if (load_a) begin
            out_a_valid <= 1'b1;
            out_a_data  <= in_data;
        end else if (hand_a) begin
            out_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
        end else if (hand_a) begin
            cnt_a <= cnt_a + CNT_W'(1);
        end
    end

    //--------------------------------------------------------------------------
    // Lane B output register, same rules as lane A.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_b_valid <= 1'b0;
            out_b_data  <= '0;
        end else if (load_b) begin
            out_b_valid <= 1'b1;
            out_b_data  <= in_data;
        end else if (hand_b) begin
            out_b_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_b <= '0;
        end else if (hand_b) begin
            cnt_b <= cnt_b + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_1to2_rr.sv
module tb_demux_1to2_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_mode;
    logic       out_a_ready;
    logic       out_b_ready;

    // default-width instance
    logic       in_ready;
    logic       a_valid, b_valid;
    logic [3:0] a_data, b_data;
    logic [7:0] cnt_a, cnt_b;

    // narrow-counter instance (CNT_W = 2), same stimulus
    logic       w_in_ready;
    logic       w_a_valid, w_b_valid;
    logic [3:0] w_a_data, w_b_data;
    logic [1:0] w_cnt_a, w_cnt_b;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    demux_1to2_rr #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_mode(in_mode),
        .out_a_valid(a_valid), .out_a_ready(out_a_ready), .out_a_data(a_data),
        .out_b_valid(b_valid), .out_b_ready(out_b_ready), .out_b_data(b_data),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    demux_1to2_rr #(.WIDTH(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_mode(in_mode),
        .out_a_valid(w_a_valid), .out_a_ready(out_a_ready), .out_a_data(w_a_data),
        .out_b_valid(w_b_valid), .out_b_ready(out_b_ready), .out_b_data(w_b_data),
        .cnt_a(w_cnt_a), .cnt_b(w_cnt_b)
    );

    //--------------------------------------------------------------------------
    // Reference model: each lane is a FIFO of at most one word plus the last
    // word written; counts are plain integers reduced modulo at compare time;
    // the round-robin lane is the parity of round-robin accepts so far.
    //--------------------------------------------------------------------------
    logic [3:0]  qa[$];
    logic [3:0]  qb[$];
    logic [3:0]  last_a, last_b;
    int unsigned hand_a_n, hand_b_n, rr_acc;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a   = 4'h0;
        last_b   = 4'h0;
        hand_a_n = 0;
        hand_b_n = 0;
        rr_acc   = 0;
    endtask

    function automatic int m_target();
        return in_mode ? int'(rr_acc % 2) : int'(in_sel);
    endfunction

    function automatic logic m_ready();
        int t;
        t = m_target();
        if (!rst_n) return 1'b0;
        if (t == 0) return (qa.size() == 0) || out_a_ready;
        return (qb.size() == 0) || out_b_ready;
    endfunction

    // Called just after a rising edge; inputs are still those of the cycle.
    task automatic model_edge();
        logic acc;
        int   t;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = in_valid && m_ready();
        t   = m_target();
        if (qa.size() != 0 && out_a_ready) begin
            void'(qa.pop_front());
            hand_a_n++;
        end
        if (qb.size() != 0 && out_b_ready) begin
            void'(qb.pop_front());
            hand_b_n++;
        end
        if (acc) begin
            if (t == 0) begin qa.push_back(in_data); last_a = in_data; end
            else        begin qb.push_back(in_data); last_b = in_data; end
            if (in_mode) rr_acc++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ready"},   32'(in_ready),    32'(m_ready()));
        chk({tag, "_a_valid"}, 32'(a_valid),     32'(qa.size() != 0));
        chk({tag, "_a_data"},  32'(a_data),      32'(last_a));
        chk({tag, "_b_valid"}, 32'(b_valid),     32'(qb.size() != 0));
        chk({tag, "_b_data"},  32'(b_data),      32'(last_b));
        chk({tag, "_cnt_a"},   32'(cnt_a),       hand_a_n % 256);
        chk({tag, "_cnt_b"},   32'(cnt_b),       hand_b_n % 256);
        chk({tag, "_w_ready"}, 32'(w_in_ready),  32'(m_ready()));
        chk({tag, "_w_a_valid"}, 32'(w_a_valid), 32'(qa.size() != 0));
        chk({tag, "_w_b_data"},  32'(w_b_data),  32'(last_b));
        chk({tag, "_w_cnt_a"}, 32'(w_cnt_a),     hand_a_n % 4);
        chk({tag, "_w_cnt_b"}, 32'(w_cnt_b),     hand_b_n % 4);
    endtask

    // Inputs are set just after a falling edge; outputs are sampled 1 time
    // unit later, well away from the rising edge.
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    //--------------------------------------------------------------------------
    // Directed vectors: inputs for one cycle and the outputs expected during
    // that same cycle (registered state from earlier edges, in_ready from the
    // current inputs). Counts are absolute since the preceding reset.
    //--------------------------------------------------------------------------
    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       sel, mode, ar, br;
        logic       rdy, av;
        logic [3:0] ad;
        logic       bv;
        logic [3:0] bd;
        int         ca, cb;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // explicit select to A
        tbl[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 0, 0};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 0, 0};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 1, 0};
        // round-robin 3,5,9,C
        tbl[3]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 1, 0};
        tbl[4]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1, 0};
        tbl[5]  = '{1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'h5, 2, 0};
        tbl[6]  = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 4'h5, 2, 1};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 4'hC, 3, 1};
        // backpressure on A, then lane B accepted past a stuck lane A
        tbl[8]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 1'b0, 4'hC, 3, 2};
        tbl[9]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 4'hC, 3, 2};
        tbl[10] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 4'hC, 3, 2};
        tbl[11] = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'hC, 3, 2};
        tbl[12] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h7, 3, 2};
        tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 4'h7, 4, 3};
        // rr pointer left at A by the earlier stream; in_sel=1 is ignored
        tbl[14] = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 4'h7, 5, 3};
        tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 4'h7, 5, 3};
        tbl[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 4'h7, 6, 3};
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 4'hF;
        in_sel      = 1'b1;
        in_mode     = 1'b1;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        repeat (2) cycle("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        in_sel      = 1'b0;
        in_mode     = 1'b0;
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset with a word offered on the input
        do_reset();

        // Directed table
        for (int i = 0; i < 17; i++) begin
            in_valid    = tbl[i].v;
            in_data     = tbl[i].d;
            in_sel      = tbl[i].sel;
            in_mode     = tbl[i].mode;
            out_a_ready = tbl[i].ar;
            out_b_ready = tbl[i].br;
            #1;
            chk($sformatf("t%0d_ready", i),   32'(in_ready),  32'(tbl[i].rdy));
            chk($sformatf("t%0d_a_valid", i), 32'(a_valid),   32'(tbl[i].av));
            chk($sformatf("t%0d_a_data", i),  32'(a_data),    32'(tbl[i].ad));
            chk($sformatf("t%0d_b_valid", i), 32'(b_valid),   32'(tbl[i].bv));
            chk($sformatf("t%0d_b_data", i),  32'(b_data),    32'(tbl[i].bd));
            chk($sformatf("t%0d_cnt_a", i),   32'(cnt_a),     32'(tbl[i].ca));
            chk($sformatf("t%0d_cnt_b", i),   32'(cnt_b),     32'(tbl[i].cb));
            chk($sformatf("t%0d_w_cnt_a", i), 32'(w_cnt_a),   32'(tbl[i].ca % 4));
            chk($sformatf("t%0d_w_cnt_b", i), 32'(w_cnt_b),   32'(tbl[i].cb % 4));
            cycle($sformatf("t%0d", i));
        end

        // Counter wrap: five lane-B handoffs after reset
        do_reset();
        in_mode     = 1'b0;
        in_sel      = 1'b1;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 1);
            cycle("wrap");
        end
        in_valid = 1'b0;
        repeat (2) cycle("wrap_idle");
        #1;
        chk("wrap_w_cnt_b", 32'(w_cnt_b), 32'd1);
        chk("wrap_cnt_b",   32'(cnt_b),   32'd5);
        chk("wrap_b_data",  32'(b_data),  32'h5);

        // Fill both lanes, then reset asynchronously mid-cycle
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        in_valid    = 1'b1;
        in_sel      = 1'b0;
        in_data     = 4'h8;
        cycle("fill_a");
        in_sel  = 1'b1;
        in_data = 4'h9;
        cycle("fill_b");
        in_valid = 1'b0;
        #1;
        chk("full_a_valid", 32'(a_valid), 32'd1);
        chk("full_b_valid", 32'(b_valid), 32'd1);
        chk("full_ready",   32'(in_ready), 32'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_a_valid", 32'(a_valid),   32'd0);
        chk("async_b_valid", 32'(b_valid),   32'd0);
        chk("async_a_data",  32'(a_data),    32'd0);
        chk("async_cnt_b",   32'(cnt_b),     32'd0);
        chk("async_w_cnt_b", 32'(w_cnt_b),   32'd0);
        chk("async_ready",   32'(in_ready),  32'd0);
        @(negedge clk);
        do_reset();

        // First round-robin accept after reset lands on lane A
        in_mode  = 1'b1;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hE;
        cycle("rr_first");
        in_valid = 1'b0;
        #1;
        chk("rr_first_a_valid", 32'(a_valid), 32'd1);
        chk("rr_first_a_data",  32'(a_data),  32'hE);
        chk("rr_first_b_valid", 32'(b_valid), 32'd0);
        cycle("rr_first_idle");

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = 4'($urandom);
            in_sel      = 1'($urandom);
            in_mode     = ($urandom_range(0, 2) != 0);
            out_a_ready = ($urandom_range(0, 9) < 7);
            out_b_ready = ($urandom_range(0, 9) < 6);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
